// File: rtl/dcache_write_buffer_if.sv
// Dcache/bridge write-buffer bundle: dcache write and hazard-check side plus bridge drain side.
// No storage or latency; pure signal grouping.
// Backpressure carried by wr_rdy toward the dcache and out_wr_rdy from the bridge.
interface dcache_write_buffer_if #(
    parameter int LINE_WIDTH = 256
);
    // dcache write side
    logic                  wr_req;
    logic [2:0]            wr_type;
    logic [31:0]           wr_addr;
    logic [3:0]            wr_wstrb;
    logic [LINE_WIDTH-1:0] wr_data;
    logic                  wr_rdy;

    // dcache read hazard check
    logic                  rd_req;
    logic [31:0]           rd_addr;
    logic                  rd_conflict;

    // bridge drain side
    logic                  out_wr_req;
    logic [2:0]            out_wr_type;
    logic [31:0]           out_wr_addr;
    logic [3:0]            out_wr_wstrb;
    logic [LINE_WIDTH-1:0] out_wr_data;
    logic                  out_wr_rdy;
    logic                  write_buffer_empty;

    // Environment view: drives dcache requests and bridge ready
    modport master (
        output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        output rd_req, rd_addr,
        output out_wr_rdy,
        input  wr_rdy, rd_conflict,
        input  out_wr_req, out_wr_type, out_wr_addr, out_wr_wstrb, out_wr_data,
        input  write_buffer_empty
    );

    // Write buffer view
    modport slave (
        input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        input  rd_req, rd_addr,
        input  out_wr_rdy,
        output wr_rdy, rd_conflict,
        output out_wr_req, out_wr_type, out_wr_addr, out_wr_wstrb, out_wr_data,
        output write_buffer_empty
    );
endinterface

// File: rtl/dcache_write_buffer.sv
// Dcache write buffer: queues line write-backs and uncached writes in FIFO order toward the bridge.
// Latency: push at edge N presents the entry on out_wr_* after edge N; 1 push + 1 pop per cycle.
// Backpressure: wr_rdy drops at full (a same-cycle pop does not free the slot); out_wr_* hold while !out_wr_rdy.
module dcache_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int LINE_WIDTH = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    dcache_write_buffer_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [2:0]            wr_type;
        logic [31:0]           addr;
        logic [3:0]            wstrb;
        logic [LINE_WIDTH-1:0] data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic               wr_rdy;
    logic               out_req;
    logic               push;
    logic               pop;
    logic               line_hit;
    entry_t             head_ent;
    logic               rd_addr_unused;

    // Readiness depends only on registered occupancy, so a pop never makes room for a same-cycle push.
    assign wr_rdy  = (count != FULL_CNT) && !reset;
    assign out_req = (count != '0);
    assign push    = bus.wr_req && wr_rdy;
    assign pop     = out_req && bus.out_wr_rdy;

    assign bus.wr_rdy             = wr_rdy;
    assign bus.out_wr_req         = out_req;
    assign bus.write_buffer_empty = (count == '0);

    // Hazard match is line-granular; the offset within the line is irrelevant.
    assign rd_addr_unused = ^bus.rd_addr[4:0];

    // Entry payload capture at the tail; payload needs no reset since valid bits qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{wr_type: bus.wr_type,
                           addr:    bus.wr_addr,
                           wstrb:   bus.wr_wstrb,
                           data:    bus.wr_data};
        end
    end

    // Pointer, occupancy and valid-bit bookkeeping; reset discards every queued entry at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            // head and tail only coincide when empty (no pop) or full (no push), so these never collide
            if (push) begin
                tail        <= tail + PTR_W'(1);
                valid[tail] <= 1'b1;
            end
            if (pop) begin
                head        <= head + PTR_W'(1);
                valid[head] <= 1'b0;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry presented to the bridge straight from storage; zeroed while the buffer is empty.
    always_comb begin
        head_ent         = mem[head];
        bus.out_wr_type  = '0;
        bus.out_wr_addr  = '0;
        bus.out_wr_wstrb = '0;
        bus.out_wr_data  = '0;
        if (out_req) begin
            bus.out_wr_type  = head_ent.wr_type;
            bus.out_wr_addr  = head_ent.addr;
            bus.out_wr_wstrb = head_ent.wstrb;
            bus.out_wr_data  = head_ent.data;
        end
    end

    // Read hazard: any currently valid entry on the same 32-byte line, including one popping this cycle.
    always_comb begin
        line_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (mem[i].addr[31:5] == bus.rd_addr[31:5])) begin
                line_hit = 1'b1;
            end
        end
        bus.rd_conflict = bus.rd_req && line_hit;
    end

endmodule

// File: tb/tb_dcache_write_buffer.sv
module tb_dcache_write_buffer;
    localparam int DEPTH = 4;
    localparam int LW    = 256;

    logic clk;
    logic reset;

    dcache_write_buffer_if #(.LINE_WIDTH(LW)) bif ();

    dcache_write_buffer #(.DEPTH(DEPTH), .LINE_WIDTH(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model: queue of accepted writes ----------------
    typedef struct {
        logic [2:0]    wr_type;
        logic [31:0]   addr;
        logic [3:0]    wstrb;
        logic [LW-1:0] data;
    } ent_t;

    ent_t mq[$];
    ent_t nent;
    bit   m_pop;
    bit   m_push;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            m_pop  = (mq.size() != 0) && bif.out_wr_rdy;
            m_push = bif.wr_req && (mq.size() != DEPTH);
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                nent.wr_type = bif.wr_type;
                nent.addr    = bif.wr_addr;
                nent.wstrb   = bif.wr_wstrb;
                nent.data    = bif.wr_data;
                mq.push_back(nent);
            end
        end
    end

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every output against what the queue model says the buffer must show right now.
    task automatic check_model(input string tag);
        bit exp_rdy, exp_req, exp_conf;
        ent_t h;
        exp_rdy  = (mq.size() != DEPTH) && !reset;
        exp_req  = (mq.size() != 0);
        exp_conf = 1'b0;
        foreach (mq[i]) if ((mq[i].addr >> 5) == (bif.rd_addr >> 5)) exp_conf = 1'b1;
        exp_conf = exp_conf && bif.rd_req;
        h = '{3'b0, 32'h0, 4'h0, '0};
        if (exp_req) h = mq[0];
        check({tag, " m.wr_rdy"}, LW'(bif.wr_rdy), LW'(exp_rdy));
        check({tag, " m.out_wr_req"}, LW'(bif.out_wr_req), LW'(exp_req));
        check({tag, " m.empty"}, LW'(bif.write_buffer_empty), LW'(!exp_req));
        check({tag, " m.rd_conflict"}, LW'(bif.rd_conflict), LW'(exp_conf));
        check({tag, " m.type"}, LW'(bif.out_wr_type), LW'(h.wr_type));
        check({tag, " m.addr"}, LW'(bif.out_wr_addr), LW'(h.addr));
        check({tag, " m.wstrb"}, LW'(bif.out_wr_wstrb), LW'(h.wstrb));
        check({tag, " m.data"}, bif.out_wr_data, h.data);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.wr_req     = 1'b0;
        bif.wr_type    = 3'b000;
        bif.wr_addr    = 32'h0;
        bif.wr_wstrb   = 4'h0;
        bif.wr_data    = '0;
        bif.rd_req     = 1'b0;
        bif.rd_addr    = 32'h0;
        bif.out_wr_rdy = 1'b0;
    endtask

    task automatic drive_wr(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                            input logic [LW-1:0] d);
        bif.wr_req   = 1'b1;
        bif.wr_type  = t;
        bif.wr_addr  = a;
        bif.wr_wstrb = s;
        bif.wr_data  = d;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        bit        wr_req;
        bit [2:0]  wr_type;
        bit [31:0] wr_addr;
        bit        out_rdy;
        bit        rd_req;
        bit [31:0] rd_addr;
        bit        e_rdy;
        bit        e_req;
        bit [31:0] e_addr;
        bit        e_conf;
    } vec_t;

    function automatic vec_t mkv(bit wq, bit [2:0] wt, bit [31:0] wa, bit orr, bit rq, bit [31:0] ra,
                                 bit er, bit eq, bit [31:0] ea, bit ec);
        vec_t v;
        v.wr_req = wq; v.wr_type = wt; v.wr_addr = wa; v.out_rdy = orr;
        v.rd_req = rq; v.rd_addr = ra;
        v.e_rdy = er; v.e_req = eq; v.e_addr = ea; v.e_conf = ec;
        return v;
    endfunction

    vec_t vt [15];

    logic [LW-1:0] line_data;
    logic [LW-1:0] rdata;
    string         tg;

    initial begin
        // fill to full, dropped 5th push, in-order drain, pop-at-empty, line conflict cases
        vt[0]  = mkv(1, 3'b010, 32'hBFAF_F000, 0, 0, 32'h0,        1, 0, 32'h0,        0);
        vt[1]  = mkv(1, 3'b010, 32'hBFAF_F004, 0, 0, 32'h0,        1, 1, 32'hBFAF_F000, 0);
        vt[2]  = mkv(1, 3'b010, 32'hBFAF_F008, 0, 0, 32'h0,        1, 1, 32'hBFAF_F000, 0);
        vt[3]  = mkv(1, 3'b010, 32'hBFAF_F00C, 0, 0, 32'h0,        1, 1, 32'hBFAF_F000, 0);
        vt[4]  = mkv(1, 3'b010, 32'hDEAD_0000, 0, 1, 32'hBFAF_F01C, 0, 1, 32'hBFAF_F000, 1);
        vt[5]  = mkv(0, 3'b000, 32'h0,        1, 0, 32'h0,        0, 1, 32'hBFAF_F000, 0);
        vt[6]  = mkv(0, 3'b000, 32'h0,        1, 0, 32'h0,        1, 1, 32'hBFAF_F004, 0);
        vt[7]  = mkv(0, 3'b000, 32'h0,        1, 0, 32'h0,        1, 1, 32'hBFAF_F008, 0);
        vt[8]  = mkv(0, 3'b000, 32'h0,        1, 0, 32'h0,        1, 1, 32'hBFAF_F00C, 0);
        vt[9]  = mkv(0, 3'b000, 32'h0,        1, 1, 32'hBFAF_F000, 1, 0, 32'h0,        0);
        vt[10] = mkv(1, 3'b100, 32'h0000_1020, 0, 1, 32'h0000_103C, 1, 0, 32'h0,        0);
        vt[11] = mkv(0, 3'b000, 32'h0,        0, 1, 32'h0000_103C, 1, 1, 32'h0000_1020, 1);
        vt[12] = mkv(0, 3'b000, 32'h0,        0, 1, 32'h0000_1040, 1, 1, 32'h0000_1020, 0);
        vt[13] = mkv(0, 3'b000, 32'h0,        1, 1, 32'h0000_103C, 1, 1, 32'h0000_1020, 1);
        vt[14] = mkv(0, 3'b000, 32'h0,        0, 1, 32'h0000_103C, 1, 0, 32'h0,        0);

        line_data = 256'h201F1E1D_1C1B1A19_18171615_14131211_100F0E0D_0C0B0A09_08070605_04030201;

        // ---- reset state ----
        idle();
        reset = 1'b1;
        bif.rd_req = 1'b1;
        #1;
        check("rst out_wr_req", LW'(bif.out_wr_req), LW'(0));
        check("rst empty", LW'(bif.write_buffer_empty), LW'(1));
        check("rst rd_conflict", LW'(bif.rd_conflict), LW'(0));
        check("rst wr_rdy", LW'(bif.wr_rdy), LW'(0));
        tick();
        reset = 1'b0;
        idle();
        #1;
        check("post-rst wr_rdy", LW'(bif.wr_rdy), LW'(1));
        tick();

        // ---- basic pass-through ----
        drive_wr(3'b100, 32'h1C00_0040, 4'hF, line_data);
        bif.out_wr_rdy = 1'b1;
        #1;
        check("pt pre req", LW'(bif.out_wr_req), LW'(0));
        tick();
        bif.wr_req = 1'b0;
        #1;
        check("pt req", LW'(bif.out_wr_req), LW'(1));
        check("pt addr", LW'(bif.out_wr_addr), LW'(32'h1C00_0040));
        check("pt type", LW'(bif.out_wr_type), LW'(3'b100));
        check("pt data", bif.out_wr_data, line_data);
        check("pt empty0", LW'(bif.write_buffer_empty), LW'(0));
        tick();
        check("pt empty1", LW'(bif.write_buffer_empty), LW'(1));
        idle();
        tick();

        // ---- table vectors ----
        for (int i = 0; i < 15; i++) begin
            bif.wr_req     = vt[i].wr_req;
            bif.wr_type    = vt[i].wr_type;
            bif.wr_addr    = vt[i].wr_addr;
            bif.wr_wstrb   = 4'hF;
            bif.wr_data    = {8{vt[i].wr_addr}};
            bif.out_wr_rdy = vt[i].out_rdy;
            bif.rd_req     = vt[i].rd_req;
            bif.rd_addr    = vt[i].rd_addr;
            #1;
            tg = $sformatf("vec%0d", i);
            check({tg, " wr_rdy"}, LW'(bif.wr_rdy), LW'(vt[i].e_rdy));
            check({tg, " out_wr_req"}, LW'(bif.out_wr_req), LW'(vt[i].e_req));
            check({tg, " out_wr_addr"}, LW'(bif.out_wr_addr), LW'(vt[i].e_addr));
            check({tg, " rd_conflict"}, LW'(bif.rd_conflict), LW'(vt[i].e_conf));
            check_model(tg);
            tick();
        end
        idle();
        tick();

        // ---- simultaneous push/pop across the pointer wrap ----
        for (int k = 0; k < 3; k++) begin
            drive_wr(3'b010, 32'h3000_0000 + 32'(4 * k), 4'hF, LW'(k));
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            drive_wr(3'b010, 32'h3000_0000 + 32'(4 * (c + 3)), 4'hF, LW'(c + 3));
            bif.out_wr_rdy = 1'b1;
            #1;
            check($sformatf("wrap%0d addr", c), LW'(bif.out_wr_addr), LW'(32'h3000_0000 + 32'(4 * c)));
            check($sformatf("wrap%0d wr_rdy", c), LW'(bif.wr_rdy), LW'(1));
            check_model($sformatf("wrap%0d", c));
            tick();
            check($sformatf("wrap%0d count", c), LW'(dut.count), LW'(3));
        end
        bif.wr_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            check($sformatf("wrap drain%0d", j), LW'(bif.out_wr_addr), LW'(32'h3000_0000 + 32'(4 * (10 + j))));
            tick();
        end
        idle();
        #1;
        check("wrap empty", LW'(bif.write_buffer_empty), LW'(1));
        tick();

        // ---- asynchronous reset mid-operation ----
        for (int k = 0; k < 3; k++) begin
            drive_wr(3'b100, 32'h5000_0000 + 32'(32 * k), 4'hF, LW'(k));
            tick();
        end
        idle();
        bif.rd_req  = 1'b1;
        bif.rd_addr = 32'h5000_0004;
        #1;
        check("pre-rst conflict", LW'(bif.rd_conflict), LW'(1));
        #1;
        reset = 1'b1;
        #1;
        check("arst out_wr_req", LW'(bif.out_wr_req), LW'(0));
        check("arst empty", LW'(bif.write_buffer_empty), LW'(1));
        check("arst rd_conflict", LW'(bif.rd_conflict), LW'(0));
        check("arst wr_rdy", LW'(bif.wr_rdy), LW'(0));
        #1;
        reset = 1'b0;
        #1;
        check("arst release wr_rdy", LW'(bif.wr_rdy), LW'(1));
        tick();
        idle();
        drive_wr(3'b010, 32'h6000_0010, 4'hF, LW'(32'h1234_5678));
        tick();
        bif.wr_req     = 1'b0;
        bif.out_wr_rdy = 1'b1;
        #1;
        check("arst new addr", LW'(bif.out_wr_addr), LW'(32'h6000_0010));
        check_model("arst new");
        tick();
        check("arst alone empty", LW'(bif.write_buffer_empty), LW'(1));
        check("arst alone req", LW'(bif.out_wr_req), LW'(0));
        idle();
        tick();

        // ---- backpressure hold ----
        drive_wr(3'b000, 32'h0000_2003, 4'b1000, LW'(32'hAB00_0000));
        tick();
        bif.wr_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("hold%0d addr", c), LW'(bif.out_wr_addr), LW'(32'h0000_2003));
            check($sformatf("hold%0d wstrb", c), LW'(bif.out_wr_wstrb), LW'(4'b1000));
            check($sformatf("hold%0d type", c), LW'(bif.out_wr_type), LW'(3'b000));
            check($sformatf("hold%0d req", c), LW'(bif.out_wr_req), LW'(1));
            tick();
        end
        bif.out_wr_rdy = 1'b1;
        tick();
        idle();
        #1;
        check("hold drained", LW'(bif.write_buffer_empty), LW'(1));
        tick();

        // ---- randomized traffic against the queue model ----
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 8; b++) rdata[32*b +: 32] = $urandom;
            bif.wr_req     = ($urandom_range(0, 2) != 0);
            bif.wr_type    = ($urandom_range(0, 3) == 3) ? 3'b100 : 3'($urandom_range(0, 2)) & 3'b011;
            bif.wr_addr    = 32'h4000_0000 + 32'($urandom_range(0, 7) * 32) + 32'($urandom_range(0, 31));
            bif.wr_wstrb   = 4'($urandom);
            bif.wr_data    = rdata;
            bif.out_wr_rdy = $urandom_range(0, 1);
            bif.rd_req     = $urandom_range(0, 1);
            bif.rd_addr    = 32'h4000_0000 + 32'($urandom_range(0, 7) * 32) + 32'($urandom_range(0, 31));
            #1;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
